fifo_req_issuer: RTL and testbench

//  Downstream consumer of the request FIFO in the Lease Cache test harness.

---
 rtl/fifo_req_issuer.sv | 112 +++++++++++
 tb/tb_fifo_req_issuer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_req_issuer.sv
// Pops request words from the harness FIFO, decodes op/address and issues them one at a
// time to the controller under test. Define REQ_TIMEOUT_EN to enable the response timeout.
module fifo_req_issuer #(
  parameter int unsigned width          = 8,
  parameter int unsigned timeout_cycles = 255,
  parameter int unsigned cnt_width      = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 fifo_empty_i,
  input  logic [width-1:0]     fifo_dout_i,
  output logic                 fifo_rd_en_o,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic                 req_we_o,
  output logic [width-2:0]     req_addr_o,
  input  logic                 resp_valid_i,
  output logic                 busy_o,
  output logic                 err_timeout_o,
  output logic [cnt_width-1:0] issued_cnt_o
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPop      = 3'd1,
    StLoad     = 3'd2,
    StIssue    = 3'd3,
    StWaitResp = 3'd4
  } state_e;

  state_e state_q;
  logic   timeout_hit;

`ifdef REQ_TIMEOUT_EN
  localparam logic [15:0] WaitLast = 16'(timeout_cycles - 1);

  logic [15:0] wait_cnt_q;

  // Counts cycles spent in StWaitResp; restarts from 0 on every entry.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wait_cnt_q <= '0;
    end else if (state_q == StWaitResp) begin
      wait_cnt_q <= wait_cnt_q + 16'd1;
    end else begin
      wait_cnt_q <= '0;
    end
  end

  assign timeout_hit = (wait_cnt_q == WaitLast);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q       <= StIdle;
      fifo_rd_en_o  <= 1'b0;
      req_valid_o   <= 1'b0;
      req_we_o      <= 1'b0;
      req_addr_o    <= '0;
      busy_o        <= 1'b0;
      err_timeout_o <= 1'b0;
      issued_cnt_o  <= '0;
    end else begin
      fifo_rd_en_o <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!fifo_empty_i) begin
            state_q      <= StPop;
            fifo_rd_en_o <= 1'b1;
            busy_o       <= 1'b1;
          end
        end
        StPop: begin
          state_q <= StLoad;
        end
        StLoad: begin
          // FIFO data is valid here, one cycle after the pop strobe.
          req_we_o    <= fifo_dout_i[width-1];
          req_addr_o  <= fifo_dout_i[width-2:0];
          req_valid_o <= 1'b1;
          state_q     <= StIssue;
        end
        StIssue: begin
          if (req_ready_i) begin
            req_valid_o <= 1'b0;
            state_q     <= StWaitResp;
          end
        end
        StWaitResp: begin
          // A response arriving in the timeout cycle still counts as a completion.
          if (resp_valid_i) begin
            issued_cnt_o <= issued_cnt_o + cnt_width'(1);
            state_q      <= StIdle;
            busy_o       <= 1'b0;
          end else if (timeout_hit) begin
            err_timeout_o <= 1'b1;
            state_q       <= StIdle;
            busy_o        <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          req_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_req_issuer.sv
// Directed bench for fifo_req_issuer: a transaction-timeline model checked every cycle,
// plus hand-computed expectations per scenario. Honours REQ_TIMEOUT_EN like the design.
module tb_fifo_req_issuer;

  localparam int unsigned Width         = 8;
  localparam int unsigned TimeoutCycles = 4;
  localparam int unsigned CntWidth      = 16;
`ifdef REQ_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic                clk_i      = 1'b0;
  logic                reset_ni   = 1'b1;
  logic                fifo_empty;
  logic [Width-1:0]    fifo_dout  = '0;
  logic                fifo_rd_en;
  logic                req_valid;
  logic                req_ready  = 1'b0;
  logic                req_we;
  logic [Width-2:0]    req_addr;
  logic                resp_valid = 1'b0;
  logic                busy;
  logic                err_timeout;
  logic [CntWidth-1:0] issued_cnt;

  // Bench-side FIFO feeding the DUT, and the model's copy of what was pushed.
  logic [Width-1:0] fifo_q[$];
  logic [Width-1:0] exp_q[$];
  logic [Width-1:0] hs_log[$];

  assign fifo_empty = (fifo_q.size() == 0);

  // Model: one request lives for a timeline measured in cycles since its pop.
  bit                  m_active = 1'b0;
  int                  m_age    = 0;
  bit                  m_acc    = 1'b0;
  int                  m_wait   = 0;
  logic [Width-1:0]    m_entry  = '0;
  logic                m_we     = 1'b0;
  logic [Width-2:0]    m_addr   = '0;
  logic                m_err    = 1'b0;
  logic [CntWidth-1:0] m_cnt    = '0;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_req_issuer #(
    .width         (Width),
    .timeout_cycles(TimeoutCycles),
    .cnt_width     (CntWidth)
  ) dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .fifo_empty_i (fifo_empty),
    .fifo_dout_i  (fifo_dout),
    .fifo_rd_en_o (fifo_rd_en),
    .req_valid_o  (req_valid),
    .req_ready_i  (req_ready),
    .req_we_o     (req_we),
    .req_addr_o   (req_addr),
    .resp_valid_i (resp_valid),
    .busy_o       (busy),
    .err_timeout_o(err_timeout),
    .issued_cnt_o (issued_cnt)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push(input logic [Width-1:0] word);
    fifo_q.push_back(word);
    exp_q.push_back(word);
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk_i or negedge reset_ni);
      if (!reset_ni) begin
        m_active = 1'b0;
        m_age    = 0;
        m_acc    = 1'b0;
        m_wait   = 0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_err    = 1'b0;
        m_cnt    = '0;
      end else begin
        if (fifo_rd_en && fifo_q.size() != 0) fifo_dout <= fifo_q.pop_front();
        if (req_valid && req_ready) hs_log.push_back({req_we, req_addr});
        if (!m_active) begin
          if (exp_q.size() != 0) begin
            m_active = 1'b1;
            m_age    = 0;
            m_acc    = 1'b0;
            m_wait   = 0;
            m_entry  = exp_q.pop_front();
          end
        end else begin
          if (m_age == 1) begin
            m_we   = m_entry[Width-1];
            m_addr = m_entry[Width-2:0];
          end
          if (m_acc) begin
            if (resp_valid) begin
              m_cnt    = m_cnt + 16'd1;
              m_active = 1'b0;
            end else if (TimeoutEn && m_wait == int'(TimeoutCycles) - 1) begin
              m_err    = 1'b1;
              m_active = 1'b0;
            end else begin
              m_wait++;
            end
          end else if (m_age >= 2 && req_ready) begin
            m_acc = 1'b1;
          end
          m_age++;
        end
      end
    end
  endtask

  task automatic compare_loop();
    logic exp_rd, exp_valid;
    forever begin
      @(negedge clk_i);
      exp_rd    = m_active && (m_age == 0);
      exp_valid = m_active && (m_age >= 2) && !m_acc;
      check("cycle", {fifo_rd_en, req_valid, req_we, req_addr, busy, err_timeout, issued_cnt},
            {exp_rd, exp_valid, m_we, m_addr, m_active, m_err, m_cnt});
    end
  endtask

  task automatic watchdog();
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not finish");
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 12 && !req_valid; i++) @(negedge clk_i);
    check(name, req_valid, 1);
  endtask

  task automatic wait_cnt(input string name, input logic [CntWidth-1:0] target, input int budget);
    for (int i = 0; i < budget && issued_cnt != target; i++) @(negedge clk_i);
    check(name, issued_cnt, target);
  endtask

  initial begin
    int          rd_cnt;
    logic        rd_seen;
    logic        got_we;
    logic [6:0]  got_addr;
    int          n;
    logic        stable;
    int          waits;
    int          base;

    fork
      model_loop();
      compare_loop();
      watchdog();
    join_none

    // 1: reset held low, FIFO empty.
    reset_ni = 1'b0;
    rd_seen  = 1'b0;
    repeat (3) begin
      @(negedge clk_i);
      rd_seen |= fifo_rd_en;
    end
    check("t1_reset_outputs",
          {fifo_rd_en, req_valid, req_we, req_addr, busy, err_timeout, issued_cnt}, 0);
    reset_ni = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      rd_seen |= fifo_rd_en;
    end
    check("t1_idle_no_pop", {rd_seen, busy}, 0);

    // 2: single write request with a zero-wait controller.
    req_ready  = 1'b1;
    resp_valid = 1'b1;
    rd_cnt     = 0;
    got_we     = 1'b0;
    got_addr   = '0;
    push(8'h85);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (fifo_rd_en) rd_cnt++;
      if (req_valid) begin
        got_we   = req_we;
        got_addr = req_addr;
      end
      if (issued_cnt == 16'd1) break;
    end
    check("t2_cnt", issued_cnt, 1);
    check("t2_model_cnt", m_cnt, 1);
    check("t2_rd_pulses", rd_cnt, 1);
    check("t2_we", got_we, 1);
    check("t2_addr", got_addr, 7'h05);
    check("t2_idle", busy, 0);

    // 3: ready held low for 4 valid cycles.
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    push(8'h12);
    wait_valid("t3_valid_seen");
    n      = 1;
    stable = (req_we == 1'b0) && (req_addr == 7'h12);
    repeat (4) begin
      @(negedge clk_i);
      n += int'(req_valid);
      if (req_we !== 1'b0 || req_addr !== 7'h12) stable = 1'b0;
    end
    req_ready = 1'b1;
    @(negedge clk_i);
    check("t3_valid_cycles", n, 5);
    check("t3_stable", stable, 1);
    check("t3_valid_dropped", req_valid, 0);
    req_ready = 1'b0;
    @(negedge clk_i);
    check("t3_no_reissue", {req_valid, busy}, 2'b01);
    resp_valid = 1'b1;
    wait_cnt("t3_cnt", 16'd2, 3);
    resp_valid = 1'b0;

    // 4: no response from the controller.
    req_ready = 1'b1;
    push(8'h40);
    wait_valid("t4_valid_seen");
    if (TimeoutEn) begin
      waits = 0;
      for (int i = 0; i < 20 && !err_timeout; i++) begin
        @(negedge clk_i);
        if (!err_timeout && busy && !req_valid) waits++;
      end
      check("t4_err", err_timeout, 1);
      check("t4_wait_cycles", waits, 4);
      check("t4_cnt_unchanged", issued_cnt, 2);
      check("t4_idle", busy, 0);
      resp_valid = 1'b1;
      push(8'h07);
      wait_cnt("t4_next_issued", 16'd3, 20);
      check("t4_err_sticky", err_timeout, 1);
    end else begin
      repeat (12) @(negedge clk_i);
      check("t4_still_waiting", {busy, req_valid, err_timeout}, 3'b100);
      resp_valid = 1'b1;
      wait_cnt("t4_late_resp", 16'd3, 4);
      check("t4_no_err", err_timeout, 0);
    end

    // 5: three back-to-back entries after a fresh reset.
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    @(negedge clk_i);
    #2 reset_ni = 1'b0;
    @(negedge clk_i);
    reset_ni = 1'b1;
    check("t5_reset_clears", {err_timeout, issued_cnt}, 0);
    base       = hs_log.size();
    req_ready  = 1'b1;
    resp_valid = 1'b1;
    push(8'h01);
    push(8'h82);
    push(8'h03);
    wait_cnt("t5_cnt", 16'd3, 60);
    check("t5_model_cnt", m_cnt, 3);
    check("t5_hs_count", hs_log.size() - base, 3);
    if (hs_log.size() - base == 3) begin
      check("t5_req0", hs_log[base],     8'h01);
      check("t5_req1", hs_log[base + 1], 8'h82);
      check("t5_req2", hs_log[base + 2], 8'h03);
    end
    rd_seen = 1'b0;
    repeat (5) begin
      @(negedge clk_i);
      rd_seen |= fifo_rd_en;
    end
    check("t5_stays_idle", {rd_seen, busy}, 0);

    // 6: reset lands while waiting for a response.
    resp_valid = 1'b0;
    push(8'h55);
    wait_valid("t6_valid_seen");
    @(negedge clk_i);
    @(negedge clk_i);
    check("t6_in_wait", {busy, req_valid}, 2'b10);
    #2 reset_ni = 1'b0;
    #1;
    check("t6_async_reset",
          {fifo_rd_en, req_valid, req_we, req_addr, busy, err_timeout, issued_cnt}, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_ni   = 1'b1;
    resp_valid = 1'b1;
    repeat (4) @(negedge clk_i);
    check("t6_resp_ignored", {busy, issued_cnt}, 0);
    resp_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
